// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute sequencer for the 8-bit RISC CPU.
// Owns the program counter, the instruction register and the 8-phase
// instruction cycle. It drives the synchronous program/data memory and
// emits accumulator/ALU control. Outputs decode only registered state.
module cpu_sequencer #(
    parameter int          ADDR_W   = 5,
    parameter int          DATA_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              zero,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              data_e,
    output logic              ld_ac,
    output logic [2:0]        alu_op,
    output logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        phase
);

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    phase_t            phase_q, phase_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              halt_q, halt_d;

    opcode_t           opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic              is_memop;
    logic              is_sto;

    assign opcode   = opcode_t'(ir_q[DATA_W-1 -: 3]);
    assign ir_addr  = ir_q[ADDR_W-1:0];
    assign is_memop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto   = (opcode == OP_STO);

    // State register: phase, PC, IR and halt flag, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_INST_ADDR;
            pc_q    <= RESET_PC_V;
            ir_q    <= '0;
            halt_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            halt_q  <= halt_d;
        end
    end

    // Next-state logic: advance the phase and update PC/IR/halt at phase ends.
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        halt_d  = halt_q;
        if (!halt_q) begin
            phase_d = phase_t'(phase_q + 3'd1);
            case (phase_q)
                PH_INST_LOAD: begin
                    ir_d = mem_data;
                end
                PH_OP_ADDR: begin
                    if (opcode == OP_HLT) begin
                        halt_d  = 1'b1;
                        phase_d = phase_q;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                PH_ALU_OP: begin
                    if (opcode == OP_JMP) begin
                        pc_d = ir_addr;
                    end else if ((opcode == OP_SKZ) && zero) begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: memory address and strobes from registered phase/IR/halt.
    always_comb begin
        mem_addr = ir_addr;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        data_e   = 1'b0;
        ld_ac    = 1'b0;
        if (!halt_q) begin
            case (phase_q)
                PH_INST_ADDR: begin
                    mem_addr = pc_q;
                end
                PH_INST_FETCH, PH_INST_LOAD: begin
                    mem_addr = pc_q;
                    mem_rd   = 1'b1;
                end
                PH_IDLE: begin
                    mem_addr = pc_q;
                end
                PH_OP_ADDR: begin
                    mem_addr = ir_addr;
                end
                PH_OP_FETCH: begin
                    mem_rd = is_memop;
                end
                PH_ALU_OP: begin
                    mem_rd = is_memop;
                    data_e = is_sto;
                end
                PH_STORE: begin
                    mem_rd = is_memop;
                    ld_ac  = is_memop;
                    mem_wr = is_sto;
                    data_e = is_sto;
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_op = ir_q[DATA_W-1 -: 3];
    assign halt   = halt_q;
    assign pc     = pc_q;
    assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed bench for cpu_sequencer with a 32x8 memory model.
// Expected per-cycle outputs are queued when each instruction is issued and
// compared at the falling edge as the sequencer walks through its phases.
module tb_cpu_sequencer;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] mem_data;
    logic          zero = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic          data_e;
    logic          ld_ac;
    logic [2:0]    alu_op;
    logic          halt;
    logic [AW-1:0] pc;
    logic [2:0]    phase;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]    ph;
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic          de;
        logic          ld;
        logic          hl;
        logic [AW-1:0] pcv;
        logic          chk_op;
        logic [2:0]    op;
    } exp_t;

    exp_t sb[$];

    logic [DW-1:0] mem [32];
    logic [DW-1:0] wr_data = 8'h00;
    logic          poke_req = 1'b0;
    logic          poke_ack = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;

    always #5 clk = ~clk;

    cpu_sequencer #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RESET_PC(0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mem_data(mem_data),
        .zero    (zero),
        .mem_addr(mem_addr),
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .data_e  (data_e),
        .ld_ac   (ld_ac),
        .alu_op  (alu_op),
        .halt    (halt),
        .pc      (pc),
        .phase   (phase)
    );

    // Synchronous memory model; bench pokes are applied here so one process owns the array.
    always @(posedge clk) begin
        if (poke_req != poke_ack) begin
            mem[poke_addr] <= poke_data;
            poke_ack       <= poke_req;
        end else if (mem_wr) begin
            mem[mem_addr] <= wr_data;
        end
        if (mem_rd) begin
            mem_data <= mem[mem_addr];
        end
    end

    task automatic checkField(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every cycle outside reset: rd/wr exclusive, ld_ac and mem_wr only in phase 7.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(mem_rd && mem_wr)) else begin
                failures++;
                $error("[TB] FAIL inv_rd_wr observed=%0b%0b expected=not both", mem_rd, mem_wr);
            end
            checks++;
            assert ((phase == 3'd7) || (!ld_ac && !mem_wr)) else begin
                failures++;
                $error("[TB] FAIL inv_p7_only observed=ph%0d ld%0b wr%0b expected=ld0 wr0", phase, ld_ac, mem_wr);
            end
        end
    end

    task automatic pokeMem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        poke_addr = a;
        poke_data = d;
        poke_req  = ~poke_req;
    endtask

    // Queue the expected outputs for one instruction fetched at pcv.
    task automatic applyStimulus(input logic [AW-1:0] pcv, input logic [DW-1:0] irv,
                                 input logic z, input int halt_cycles);
        exp_t          e;
        logic [2:0]    op;
        logic          memop;
        logic          sto;
        logic [AW-1:0] pc1;
        logic [AW-1:0] pc_end;
        op     = irv[7:5];
        memop  = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        sto    = (op == 3'd6);
        pc1    = pcv + 5'd1;
        pc_end = pc1;
        if (op == 3'd7)
            pc_end = irv[4:0];
        else if ((op == 3'd1) && z)
            pc_end = pcv + 5'd2;
        zero = z;
        for (int p = 0; p < 8; p++) begin
            if ((op == 3'd0) && (p > 4))
                break;
            e.ph     = 3'(p);
            e.addr   = (p < 4) ? pcv : irv[4:0];
            e.rd     = (p == 1) || (p == 2) || (memop && (p >= 5));
            e.wr     = sto && (p == 7);
            e.de     = sto && (p >= 6);
            e.ld     = memop && (p == 7);
            e.hl     = 1'b0;
            e.pcv    = (p <= 4) ? pcv : ((p == 7) ? pc_end : pc1);
            e.chk_op = (p >= 3);
            e.op     = op;
            sb.push_back(e);
        end
        for (int i = 0; i < halt_cycles; i++) begin
            e.ph     = 3'd4;
            e.addr   = irv[4:0];
            e.rd     = 1'b0;
            e.wr     = 1'b0;
            e.de     = 1'b0;
            e.ld     = 1'b0;
            e.hl     = 1'b1;
            e.pcv    = pcv;
            e.chk_op = 1'b1;
            e.op     = op;
            sb.push_back(e);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=entry");
            return;
        end
        e = sb.pop_front();
        checkField($sformatf("pc%0d_p%0d_phase", e.pcv, e.ph), 8'(phase), 8'(e.ph));
        checkField($sformatf("p%0d_addr", e.ph), 8'(mem_addr), 8'(e.addr));
        checkField($sformatf("p%0d_rd", e.ph), 8'(mem_rd), 8'(e.rd));
        checkField($sformatf("p%0d_wr", e.ph), 8'(mem_wr), 8'(e.wr));
        checkField($sformatf("p%0d_data_e", e.ph), 8'(data_e), 8'(e.de));
        checkField($sformatf("p%0d_ld_ac", e.ph), 8'(ld_ac), 8'(e.ld));
        checkField($sformatf("p%0d_halt", e.ph), 8'(halt), 8'(e.hl));
        checkField($sformatf("p%0d_pc", e.ph), 8'(pc), 8'(e.pcv));
        if (e.chk_op)
            checkField($sformatf("p%0d_alu_op", e.ph), 8'(alu_op), 8'(e.op));
    endtask

    task automatic runQueued();
        while (sb.size() > 0) begin
            checkOutput();
            @(negedge clk);
        end
    endtask

    task automatic resetDut();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkField("rst_phase", 8'(phase), 8'd0);
        checkField("rst_pc", 8'(pc), 8'd0);
        checkField("rst_halt", 8'(halt), 8'd0);
        checkField("rst_addr", 8'(mem_addr), 8'd0);
        checkField("rst_rd", 8'(mem_rd), 8'd0);
        checkField("rst_wr", 8'(mem_wr), 8'd0);
        checkField("rst_data_e", 8'(data_e), 8'd0);
        checkField("rst_ld_ac", 8'(ld_ac), 8'd0);
    endtask

    // Directed program: LDA, STO, SKZ both ways, JMP, PC wrap, HLT, reset during STO.
    initial begin
        wr_data = 8'h9D;
        repeat (2) @(negedge clk);
        pokeMem(5'd0,  8'hA5); @(negedge clk);
        pokeMem(5'd1,  8'hDF); @(negedge clk);
        pokeMem(5'd2,  8'h20); @(negedge clk);
        pokeMem(5'd4,  8'h20); @(negedge clk);
        pokeMem(5'd5,  8'h3C); @(negedge clk);
        pokeMem(5'd6,  8'hFE); @(negedge clk);
        pokeMem(5'd30, 8'h7F); @(negedge clk);
        resetDut();

        applyStimulus(5'd0, 8'hA5, 1'b0, 0);  runQueued();
        applyStimulus(5'd1, 8'hDF, 1'b0, 0);  runQueued();
        checkField("sto_mem31", mem[31], 8'h9D);
        applyStimulus(5'd2, 8'h20, 1'b1, 0);  runQueued();
        applyStimulus(5'd4, 8'h20, 1'b0, 0);  runQueued();
        applyStimulus(5'd5, 8'h3C, 1'b0, 0);  runQueued();
        applyStimulus(5'd6, 8'hFE, 1'b0, 0);  runQueued();
        applyStimulus(5'd30, 8'h7F, 1'b0, 0); runQueued();
        pokeMem(5'd0, 8'h00);
        applyStimulus(5'd31, 8'h9D, 1'b0, 0); runQueued();

        applyStimulus(5'd0, 8'h00, 1'b0, 20); runQueued();
        resetDut();

        wr_data = 8'h55;
        pokeMem(5'd0, 8'hDF);
        applyStimulus(5'd0, 8'hDF, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            checkOutput();
            @(negedge clk);
        end
        checkOutput();
        resetDut();
        checkField("rst_p7_mem31", mem[31], 8'h55);
        wr_data = 8'hAA;
        pokeMem(5'd0, 8'hB1);
        applyStimulus(5'd0, 8'hB1, 1'b0, 0);  runQueued();
        checkField("after_rst_mem31", mem[31], 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Fetch/execute sequencer for the 8-bit RISC CPU, sitting directly upstream of the 32x8 program/data memory.
- The memory is synchronous: one-cycle registered read, write on the rising edge, and rd/wr must be mutually exclusive.
- This block owns the program counter (PC), the instruction register (IR) and an 8-phase instruction cycle.
- It drives the memory address, rd and wr, and emits accumulator/ALU control. The instruction format is opcode IR[7:5] plus a 5-bit address IR[4:0].

Parameters:
- ADDR_W, 5, memory address width and PC width.
- DATA_W, 8, instruction/data word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock, shared with memory.
- rst  in  1  synchronous, active-high reset.
- mem_data  in  DATA_W  memory data_out.
- zero  in  1  accumulator==0 flag.
- mem_addr  out  ADDR_W  memory addr.
- mem_rd  out  1  memory rd.
- mem_wr  out  1  memory wr.
- data_e  out  1  enable accumulator onto memory data_in.
- ld_ac  out  1  accumulator load strobe (ALU result from mem_data).
- alu_op  out  3  opcode to ALU (= IR[7:5]).
- halt  out  1  CPU halted.
- pc  out  ADDR_W  current PC (debug).
- phase  out  3  current phase (debug).

Behaviour:
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. "MEMOP" means ADD, AND, XOR or LDA.
- Reset (rst=1 at posedge):
  - phase=0, PC=RESET_PC, IR=0, halt=0.
  - All strobes (mem_rd, mem_wr, data_e, ld_ac) read 0 during the cycle after reset.
  - Reset overrides any phase, including halted state and phase 7.
- Phase counter: 3-bit, increments every cycle and wraps 7 -> 0. It freezes while halt=1.
- Outputs are decoded combinationally from registered phase/IR/halt only, never from inputs.
- Per phase (registered updates happen at the end of the phase):
  - P0 INST_ADDR: mem_addr=PC, no strobes.
  - P1 INST_FETCH: mem_addr=PC, mem_rd=1. Memory data is valid in P2.
  - P2 INST_LOAD: mem_addr=PC, mem_rd=1, IR<=mem_data.
  - P3 IDLE: mem_addr=PC, no strobes.
  - P4 OP_ADDR: mem_addr=IR[4:0], PC<=PC+1 (mod 2^ADDR_W).
    - If opcode=HLT: halt<=1 instead, PC not incremented, phase frozen at 4.
  - P5 OP_FETCH: mem_addr=IR[4:0]; mem_rd=1 if MEMOP.
  - P6 ALU_OP: mem_addr=IR[4:0]; mem_rd=1 if MEMOP; data_e=1 if STO.
    - If SKZ and zero=1: PC<=PC+1.
    - If JMP: PC<=IR[4:0].
  - P7 STORE: mem_addr=IR[4:0].
    - MEMOP: mem_rd=1, ld_ac=1.
    - STO: mem_wr=1, data_e=1.
- Invariant: mem_rd and mem_wr are never both 1.
- mem_addr changes only at phase boundaries.
- PC wraps 31 -> 0 (no fault).
- SKZ with zero=0 has no effect beyond the P4 increment.
- JMP takes precedence over the P4 increment (net PC = target).
- Halt holds all strobes at 0 and mem_addr=IR[4:0]; only rst exits it.
- Latency: one instruction per 8 cycles; HLT stops after 5 cycles (P0-P4).

Test Plan:
- Fetch/LDA: rst, mem[0]=0xA5 (LDA 5), mem[5]=0x3C.
  - P1-P2: mem_addr=0, mem_rd=1.
  - IR=0xA5 after P2.
  - P5-P7: mem_addr=5; ld_ac=1 only in P7; alu_op=5.
  - pc=1 at the next P0.
- STO: mem[1]=0xDF (STO 31).
  - data_e=1 in P6-P7; mem_wr=1 only in P7 with mem_addr=31.
  - mem_rd=0 in P5-P7.
- SKZ/JMP:
  - SKZ with zero=1 at pc=2 -> pc=4 at next P0.
  - SKZ with zero=0 -> pc=3.
  - JMP 0x1E (0xFE) at any pc -> next fetch from address 30.
- HLT/wrap:
  - pc=31 non-HLT instruction -> pc=0.
  - mem[0]=0x00 -> halt=1 after P4; phase stays 4 and strobes stay 0 for 20 cycles.
  - rst -> phase=0, pc=0, halt=0.
- Reset mid-instruction: assert rst during P7 of STO.
  - mem_wr=0 in the cycle after reset.
  - Target memory word unchanged beyond that point.
  - Fetch restarts at pc=0.
- Invariant check, all tests: every cycle assert !(mem_rd && mem_wr), and ld_ac/mem_wr appear only in phase 7.
